// File: rtl/swipt_deadtime_if.sv
// Bundle of raw bridge commands in and conditioned gate drives out for swipt_deadtime.
// Latency: wiring only; no logic lives here.
// Backpressure: none; these are level signals sampled every clock.
interface swipt_deadtime_if;
  logic       enable;
  logic       pwm_in0;
  logic       pwm_in1;
  logic       pwm_in2;
  logic       pwm_in3;
  logic       fault_clr;
  logic       gate_out0;
  logic       gate_out1;
  logic       gate_out2;
  logic       gate_out3;
  logic [1:0] dt_active;
  logic       fault;

  // Command source side (PWM generator / control).
  modport master (
    output enable, pwm_in0, pwm_in1, pwm_in2, pwm_in3, fault_clr,
    input  gate_out0, gate_out1, gate_out2, gate_out3, dt_active, fault
  );

  // Dead-time stage side.
  modport slave (
    input  enable, pwm_in0, pwm_in1, pwm_in2, pwm_in3, fault_clr,
    output gate_out0, gate_out1, gate_out2, gate_out3, dt_active, fault
  );
endinterface

// File: rtl/swipt_deadtime.sv
// Dead-time insertion and shoot-through blocking for the two SWIPT full-bridge legs.
// Latency: turn-off 1 edge, turn-on DT_CYCLES edges after turn-off (+1 each with SWIPT_DT_DEGLITCH_EN).
// Backpressure: none; requests are levels, enable=0 forces every gate low at the next edge.
module swipt_deadtime #(
  parameter int DT_CYCLES = 5,
  parameter int CNT_W     = 8
) (
  input logic           clk,
  input logic           nrst,
  swipt_deadtime_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DT_CYCLES - 1);

  // Raw commands packed as {legB_lo, legB_hi, legA_lo, legA_hi}.
  logic [3:0] raw;
  logic [3:0] eff;

  assign raw = {bus.pwm_in3, bus.pwm_in2, bus.pwm_in1, bus.pwm_in0};

`ifdef SWIPT_DT_DEGLITCH_EN
  logic [3:0] smp_q;
  logic [3:0] hold_q;
  logic [3:0] chg;

  // A bit is accepted only when the live value matches the value seen at the
  // previous edge; otherwise the last accepted value is kept.
  assign chg = raw ^ smp_q;
  assign eff = (raw & ~chg) | (hold_q & chg);

  // Previous-edge sample and last accepted value of each raw input.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      smp_q  <= 4'b0000;
      hold_q <= 4'b0000;
    end else begin
      smp_q  <= raw;
      hold_q <= eff;
    end
  end
`else
  assign eff = raw;
`endif

  // Per-leg request decode; 11 is never a valid request and reads as NONE.
  logic [1:0] want_hi;
  logic [1:0] want_lo;
  logic [1:0] illegal;

  assign want_hi = {eff[2] & ~eff[3], eff[0] & ~eff[1]};
  assign want_lo = {eff[3] & ~eff[2], eff[1] & ~eff[0]};
  assign illegal = {eff[2] &  eff[3], eff[0] &  eff[1]};

  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       tgt_q;      // side DEAD is heading to: 1 = HI, 0 = LO
  logic [1:0]       tgt_d;
  logic [1:0]       gate_hi_q;
  logic [1:0]       gate_hi_d;
  logic [1:0]       gate_lo_q;
  logic [1:0]       gate_lo_d;
  logic             fault_q;
  logic             fault_d;

  // Leg FSM next state: enable and NONE force OFF; every commutation goes through DEAD.
  always_comb begin
    tgt_d     = tgt_q;
    gate_hi_d = 2'b00;
    gate_lo_d = 2'b00;
    for (int l = 0; l < 2; l++) begin
      state_d[l] = state_q[l];
      cnt_d[l]   = cnt_q[l];
      if (!bus.enable || !(want_hi[l] || want_lo[l])) begin
        state_d[l] = ST_OFF;
        cnt_d[l]   = '0;
      end else begin
        unique case (state_q[l])
          ST_OFF: begin
            state_d[l] = ST_DEAD;
            cnt_d[l]   = DT_LOAD;
            tgt_d[l]   = want_hi[l];
          end
          ST_HI: begin
            if (want_lo[l]) begin
              state_d[l] = ST_DEAD;
              cnt_d[l]   = DT_LOAD;
              tgt_d[l]   = 1'b0;
            end
          end
          ST_LO: begin
            if (want_hi[l]) begin
              state_d[l] = ST_DEAD;
              cnt_d[l]   = DT_LOAD;
              tgt_d[l]   = 1'b1;
            end
          end
          ST_DEAD: begin
            if (want_hi[l] != tgt_q[l]) begin
              // Request flipped mid dead time: restart the full interval.
              cnt_d[l] = DT_LOAD;
              tgt_d[l] = want_hi[l];
            end else if (cnt_q[l] == '0) begin
              state_d[l] = tgt_q[l] ? ST_HI : ST_LO;
            end else begin
              cnt_d[l] = cnt_q[l] - CNT_W'(1);
            end
          end
          default: begin
            state_d[l] = ST_OFF;
            cnt_d[l]   = '0;
          end
        endcase
      end
      // Gates follow the next state so turn-off happens on the sampling edge.
      gate_hi_d[l] = (state_d[l] == ST_HI);
      gate_lo_d[l] = (state_d[l] == ST_LO);
    end
  end

  // Sticky fault: a set in the same cycle as a clear wins.
  always_comb begin
    fault_d = fault_q;
    if (bus.enable && (illegal != 2'b00)) begin
      fault_d = 1'b1;
    end else if (bus.fault_clr) begin
      fault_d = 1'b0;
    end
  end

  // State, counter, gate and fault registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int l = 0; l < 2; l++) begin
        state_q[l] <= ST_OFF;
        cnt_q[l]   <= '0;
      end
      tgt_q     <= 2'b00;
      gate_hi_q <= 2'b00;
      gate_lo_q <= 2'b00;
      fault_q   <= 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        state_q[l] <= state_d[l];
        cnt_q[l]   <= cnt_d[l];
      end
      tgt_q     <= tgt_d;
      gate_hi_q <= gate_hi_d;
      gate_lo_q <= gate_lo_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.gate_out0 = gate_hi_q[0];
  assign bus.gate_out1 = gate_lo_q[0];
  assign bus.gate_out2 = gate_hi_q[1];
  assign bus.gate_out3 = gate_lo_q[1];
  assign bus.dt_active = {state_q[1] == ST_DEAD, state_q[0] == ST_DEAD};
  assign bus.fault     = fault_q;

endmodule
